// File: rtl/morse_pkg.sv
// Shared Morse definitions: key-timing FSM states and unit multiples for symbols and gaps.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } key_state_e;

  localparam int DASH_UNITS     = 2;
  localparam int CHAR_GAP_UNITS = 3;
  localparam int WORD_GAP_UNITS = 7;

  // One counter serves both press duration and gap length; the word gap is the longest span.
  function automatic int cnt_width(input int unit_cycles);
    return $clog2(WORD_GAP_UNITS * unit_cycles + 1);
  endfunction

endpackage

// File: rtl/morse_key_decoder_if.sv
// Straight-key input and decoded symbol/space strobes of the Morse front end.
interface morse_key_decoder_if;
  logic key;
  logic key_level;
  logic dot_inp;
  logic dash_inp;
  logic char_space_inp;
  logic word_space_inp;

  modport master (
    output key,
    input  key_level,
    input  dot_inp,
    input  dash_inp,
    input  char_space_inp,
    input  word_space_inp
  );

  modport slave (
    input  key,
    output key_level,
    output dot_inp,
    output dash_inp,
    output char_space_inp,
    output word_space_inp
  );
endinterface

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a debouncer that accepts a level change only after
// DEBOUNCE_CYCLES consecutive cycles of disagreement with the current level.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_level
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic [DB_W-1:0] db_cnt;

  // Stage boundary: synchroniser, then debounced level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      db_cnt    <= '0;
      key_level <= 1'b0;
    end else begin
      sync_p0 <= key;
      sync_p1 <= sync_p0;
      if (sync_p1 == key_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt    <= '0;
        key_level <= sync_p1;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/morse_key_decoder.sv
// Straight-key decoder: classifies debounced presses as dot/dash and silences as
// character/word spaces, each reported as a single registered one-cycle strobe.
module morse_key_decoder
  import morse_pkg::*;
#(
  parameter int UNIT_CYCLES     = 1_000_000,
  parameter int DEBOUNCE_CYCLES = 50_000
) (
  input  logic                clk,
  input  logic                rst,
  morse_key_decoder_if.slave  kif
);

  localparam int CNT_W = cnt_width(UNIT_CYCLES);
  localparam logic [CNT_W-1:0] DASH_LEN = CNT_W'(DASH_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] CHAR_LEN = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] WORD_LEN = CNT_W'(WORD_GAP_UNITS * UNIT_CYCLES);

  logic             key_level;
  key_state_e       state;
  key_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             dot_nxt;
  logic             dash_nxt;
  logic             char_nxt;
  logic             word_nxt;
  logic             dot_p0;
  logic             dash_p0;
  logic             char_p0;
  logic             word_p0;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk       (clk),
    .rst       (rst),
    .key       (kif.key),
    .key_level (key_level)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cnt_inc   = cnt + CNT_W'(1);
    dot_nxt   = 1'b0;
    dash_nxt  = 1'b0;
    char_nxt  = 1'b0;
    word_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (key_level) begin
          state_nxt = PRESS;
          cnt_nxt   = CNT_W'(1);
        end
      end
      PRESS: begin
        if (key_level) begin
          // Saturating at the dash threshold is enough to classify arbitrarily long presses
          if (cnt < DASH_LEN) cnt_nxt = cnt_inc;
        end else begin
          state_nxt = GAP;
          cnt_nxt   = '0;
          if (cnt < DASH_LEN) dot_nxt  = 1'b1;
          else                dash_nxt = 1'b1;
        end
      end
      GAP: begin
        // A new press wins over a space threshold reached on the same cycle
        if (key_level) begin
          state_nxt = PRESS;
          cnt_nxt   = CNT_W'(1);
        end else begin
          cnt_nxt = cnt_inc;
          if (cnt_inc == CHAR_LEN) char_nxt = 1'b1;
          if (cnt_inc == WORD_LEN) begin
            word_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage boundary: FSM state, shared counter and registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      dot_p0  <= 1'b0;
      dash_p0 <= 1'b0;
      char_p0 <= 1'b0;
      word_p0 <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      dot_p0  <= dot_nxt;
      dash_p0 <= dash_nxt;
      char_p0 <= char_nxt;
      word_p0 <= word_nxt;
    end
  end

  assign kif.key_level      = key_level;
  assign kif.dot_inp        = dot_p0;
  assign kif.dash_inp       = dash_p0;
  assign kif.char_space_inp = char_p0;
  assign kif.word_space_inp = word_p0;

endmodule

// File: tb/tb_morse_key_decoder.sv
// Bench for morse_key_decoder: directed and random key timelines checked cycle by cycle
// against an event schedule derived from press/gap lengths.
module tb_morse_key_decoder;

  localparam int U    = 10;
  localparam int D    = 3;
  localparam int LAT  = 2 + D;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  morse_key_decoder_if kif ();

  morse_key_decoder #(
    .UNIT_CYCLES     (U),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic       wave  [MAXC];
  logic [4:0] exp_v [MAXC];
  int         segs  [$];
  int         scen_len;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed vector {key_level, word, char, dash, dot}
  function automatic logic [4:0] obs();
    return {kif.key_level, kif.word_space_inp, kif.char_space_inp, kif.dash_inp, kif.dot_inp};
  endfunction

  task automatic set_ev(input int idx, input int bitpos);
    if (idx < MAXC) exp_v[idx][bitpos] = 1'b1;
  endtask

  // segs alternates gap, press, gap, press, ..., gap (key-cycle counts, first is a gap).
  // key_level is the key delayed by 2+D; a press of N cycles ending at cycle s+N gives its
  // symbol at s+N+3+D; a following silence of G key cycles yields a char space 3U later
  // when G > 3U and a word space 7U later when G > 7U.
  task automatic build();
    int t = 0;
    int ps[$];
    int pl[$];
    for (int i = 0; i < MAXC; i++) begin
      wave[i]  = 1'b0;
      exp_v[i] = '0;
    end
    foreach (segs[i]) begin
      if (i % 2 == 1) begin
        ps.push_back(t);
        pl.push_back(segs[i]);
      end
      for (int k = 0; k < segs[i]; k++) begin
        if (t < MAXC) wave[t] = (i % 2 == 1);
        t++;
      end
    end
    scen_len = (t + 10 < MAXC) ? t + 10 : MAXC;
    for (int i = LAT; i < MAXC; i++) exp_v[i][4] = wave[i - LAT];
    foreach (ps[j]) begin
      int e;
      int g;
      e = ps[j] + pl[j] + 3 + D;
      g = (j + 1 < ps.size()) ? ps[j + 1] - (ps[j] + pl[j]) : MAXC;
      set_ev(e, (pl[j] < 2 * U) ? 0 : 1);
      if (g >= 3 * U + 1) set_ev(e + 3 * U, 2);
      if (g >= 7 * U + 1) set_ev(e + 7 * U, 3);
    end
  endtask

  task automatic do_reset();
    kif.key = 1'b0;
    rst     = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("rst_out", {27'd0, obs()}, 32'd0);
    end
    rst = 1'b1;
  endtask

  task automatic run_scen(input string tag);
    build();
    for (int t = 0; t < scen_len; t++) begin
      @(posedge clk);
      #1 kif.key = wave[t];
      @(negedge clk);
      check_val($sformatf("%s@%0d", tag, t), {27'd0, obs()}, {27'd0, exp_v[t]});
    end
  endtask

  initial begin
    kif.key = 1'b0;
    rst     = 1'b0;

    // Reset held with a toggling key, then quiet release
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      kif.key = $urandom_range(0, 1);
      @(posedge clk);
      #1 check_val("rst_hold", {27'd0, obs()}, 32'd0);
    end
    @(negedge clk);
    kif.key = 1'b0;
    rst     = 1'b1;
    segs = '{200};
    run_scen("idle");

    do_reset();
    segs = '{5, 19, 150};
    run_scen("dot19");

    do_reset();
    segs = '{5, 20, 120};
    run_scen("dash20");

    do_reset();
    segs = '{5, 200, 120};
    run_scen("dash200");

    do_reset();
    segs = '{5, 19, 25, 19, 120};
    run_scen("gap25");

    do_reset();
    segs = '{5, 19, 50, 19, 120};
    run_scen("gap50");

    do_reset();
    segs = '{5, 10, 30, 10, 31, 10, 70, 10, 71, 10, 120};
    run_scen("gapedge");

    // Short glitches must never reach key_level
    do_reset();
    for (int t = 0; t < 130; t++) begin
      @(posedge clk);
      #1 kif.key = (t < 30) && (t % 3 != 2);
      @(negedge clk);
      check_val($sformatf("bounce@%0d", t), {27'd0, obs()}, 32'd0);
    end

    // Reset in the middle of a press loses it
    do_reset();
    for (int t = 0; t < 15; t++) begin
      @(posedge clk);
      #1 kif.key = 1'b1;
    end
    @(negedge clk);
    check_val("mid_lvl", {31'd0, kif.key_level}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    kif.key = 1'b0;
    #1 check_val("mid_rst", {27'd0, obs()}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    segs = '{150};
    run_scen("mid_quiet");

    // Random timelines with a bias towards the gap thresholds
    for (int s = 0; s < 8; s++) begin
      do_reset();
      segs = '{$urandom_range(1, 20)};
      for (int k = 0; k < 6; k++) begin
        int g;
        segs.push_back($urandom_range(3, 45));
        case ($urandom_range(0, 7))
          0:       g = 30;
          1:       g = 31;
          2:       g = 70;
          3:       g = 71;
          default: g = $urandom_range(3, 90);
        endcase
        segs.push_back(g);
      end
      segs[segs.size() - 1] = 120;
      run_scen($sformatf("rnd%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
# morse_key_decoder

Front-end stage for the Morse path. It turns a single raw straight-key input into the one-cycle `dot_inp`, `dash_inp`, `char_space_inp` and `word_space_inp` strobes consumed by `trans_fsm` in `morse_top`. Each press is classified by its length and each silence by its duration, using a unit length in clock cycles. Inside the block a synchroniser and debouncer sit in front of a press/gap timing FSM.

## Interface
- `UNIT_CYCLES`, default 1_000_000: length of one Morse unit (a dot) in `clk` cycles; must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 50_000: consecutive stable cycles needed to accept a key level change; must be ≥ 1.
- `clk`  in  1  system clock; all logic in one clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `key`  in  1  raw straight key, active-high, asynchronous to `clk`, may bounce.
- `key_level`  out  1  debounced key level, registered (usable as an LED echo).
- `dot_inp`  out  1  one-cycle strobe: a press shorter than 2 units ended.
- `dash_inp`  out  1  one-cycle strobe: a press of 2 units or longer ended.
- `char_space_inp`  out  1  one-cycle strobe: the gap after a symbol reached 3 units.
- `word_space_inp`  out  1  one-cycle strobe: the gap after a symbol reached 7 units.

## Operation
- **Synchroniser:** two flops on `key`, giving `key_s`.
- **Debouncer:**
  - `key_level` flips when `key_s != key_level` for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any cycle with `key_s == key_level` clears the stability counter.
- **FSM states:** IDLE, PRESS, GAP.
  - IDLE: `key_level` = 1 → PRESS, and the duration counter is loaded with 1.
  - PRESS: while `key_level` = 1, the duration counter increments and saturates at 2·UNIT_CYCLES.
  - PRESS → GAP on the first cycle with `key_level` = 0. In that transition the block emits `dot_inp` if duration < 2·UNIT_CYCLES, otherwise `dash_inp`. The gap counter is cleared.
  - GAP: the gap counter increments each cycle. When it reaches 3·UNIT_CYCLES the block pulses `char_space_inp`. When it reaches 7·UNIT_CYCLES the block pulses `word_space_inp` and goes to IDLE.
  - GAP with `key_level` = 1 → PRESS, and the duration counter is loaded with 1. Any space strobes not yet emitted are dropped.
- **No spaces from IDLE:** after reset or after a word space, silence produces no strobes.
- **Output properties:**
  - The four strobes are mutually exclusive and all outputs are registered.
  - Each event produces exactly one strobe; a strobe is never repeated or stretched.
- **Counter width:** `$clog2(7*UNIT_CYCLES+1)` bits, shared by the duration and gap counters. No arithmetic wraps; compares are unsigned.

## Timing
- **Reset values:** `rst` low clears every output to 0, the synchroniser and debounce counters to 0, the FSM to IDLE and `key_level` to 0.
- **Reset mid-press:** the press is lost and no dot or dash follows.
- **Key-to-level latency:** `key_level` follows a clean `key` edge after 2 + DEBOUNCE_CYCLES cycles. The latency is identical for both edges, so a press of N cycles gives `key_level` high for exactly N cycles.
- **Dot/dash strobe:** asserted on the clock edge where the FSM leaves PRESS, i.e. 1 cycle after the first low cycle of `key_level`.
- **Space strobes:** `char_space_inp` asserts exactly 3·UNIT_CYCLES cycles after the dot/dash strobe, and `word_space_inp` exactly 7·UNIT_CYCLES cycles after it.
- **Boundary: duration.** A duration of exactly 2·UNIT_CYCLES gives a dash; 2·UNIT_CYCLES−1 gives a dot.
- **Boundary: gap.** A press whose `key_level` rises on the same cycle the gap counter would hit 3·UNIT_CYCLES takes priority: no `char_space_inp` is emitted.
- **Key held through reset release:** treated as a normal press starting 2 + DEBOUNCE_CYCLES cycles after `rst` goes high.

## Structure
- **`morse_pkg`:**
  - FSM state typedef (IDLE/PRESS/GAP).
  - Constants DASH_UNITS = 2, CHAR_GAP_UNITS = 3, WORD_GAP_UNITS = 7.
  - Later reusable by `trans_fsm` for its own symbol encoding.
- **Sub-module `key_debounce`:** synchroniser plus debouncer, parameter DEBOUNCE_CYCLES, output `key_level`. The FSM and counters live in `morse_key_decoder`.
- **Integration:** in `morse_top`, the four strobe outputs drive the existing `trans_fsm` inputs directly.

## Test plan
All scenarios use UNIT_CYCLES = 10 and DEBOUNCE_CYCLES = 3.
- **Reset:** hold `rst` low while toggling `key` → all outputs stay 0. Release with `key` = 0 → no strobes for 200 cycles.
- **Single dot:** `key` high 19 cycles → one `dot_inp`; `char_space_inp` 30 cycles later; `word_space_inp` 70 cycles after the dot; then silence.
- **Dash boundary:** `key` high 20 cycles → one `dash_inp`. `key` high 200 cycles → one `dash_inp` (saturation).
- **Bounce rejection:** 2-cycle high glitches on `key`, 1 cycle apart → `key_level` stays 0 and no strobes occur.
- **Gap classification:**
  - dot, 25-cycle gap, dot → no space strobe between the two dots.
  - dot, 50-cycle gap, dot → one `char_space_inp` between them, no `word_space_inp`.
- **Reset mid-press:** `key` high 15 cycles, pulse `rst` low 1 cycle, `key` low → no `dot_inp` or `dash_inp`; all outputs 0 immediately on `rst` assertion.
